axis_sobol_generator: RTL and testbench

//  AXI4-Stream master source of 2-D Sobol points, in Gray-code order, upstream of the Owen scrambler.
//  On a start pulse it seeks to start_index, then streams count points, one beat per accepted cycle.

---
 rtl/sobol_pkg.sv | 36 +++
 rtl/sobol_ctz.sv | 26 ++
 rtl/axis_sobol_generator.sv | 189 ++++++++++++++++++
 tb/tb_axis_sobol_generator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobol_pkg.sv
// sobol_pkg: shared definitions for the 2-D Sobol point generator.
//   - default widths for the fraction and the sample index
//   - sobol_dir(dim, k, width): direction number Vd[k], MSB-aligned in a
//     'width'-bit fraction and returned in a 64-bit container
//   - state_t: generator FSM states
package sobol_pkg;

    localparam int SOBOL_DIMS       = 2;
    localparam int SOBOL_FRAC_BITS  = 32;
    localparam int SOBOL_INDEX_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Dimension 0 is the van der Corput sequence (one bit per k).
    // Dimension 1 uses primitive polynomial x+1: V[k] = V[k-1] ^ (V[k-1] >> 1).
    // Bits only move towards the LSB, so nothing escapes above 'width'.
    function automatic logic [63:0] sobol_dir(input int dim, input int k, input int width);
        logic [63:0] v;
        v = 64'd1 << (width - 1);
        if (dim == 0) begin
            v = v >> k;
        end else begin
            for (int i = 1; i < 64; i++) begin
                if (i <= k) begin
                    v = v ^ (v >> 1);
                end
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sobol_ctz.sv
// sobol_ctz: combinational count-trailing-zeros.
//   value    in  WIDTH   operand
//   ctz      out CW      index of the lowest set bit (0 when value is zero)
//   all_zero out 1       value == 0; the generator uses it to spot index wrap
module sobol_ctz #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    ctz,
    output logic             all_zero
);

    // Scan from the MSB down so the last hit is the lowest set bit.
    always_comb begin
        ctz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (value[i]) begin
                ctz = CW'(i);
            end
        end
    end

    assign all_zero = (value == '0);

endmodule

// File: rtl/axis_sobol_generator.sv
// axis_sobol_generator: AXI4-Stream source of 2-D Sobol points in Gray-code
// order. A start pulse seeks to start_index, then count points are streamed.
//   m00_axis_aclk / m00_axis_areset : clock, synchronous active-high reset
//   start, start_index, count       : burst request (sampled together in IDLE)
//   busy, done                      : burst in progress / one-cycle end pulse
//   m00_axis_t{valid,ready,last,data,strb} : stream, tdata = {dim1, dim0}
//   sample_index                    : Sobol index of the point on tdata
// Optional feature: define SOBOL_SKIP_ZERO_EN to never emit index 0
// (a start_index of 0 becomes 1, and index wrap lands on 1 instead of 0).
module axis_sobol_generator
    import sobol_pkg::*;
#(
    parameter int DIMS                   = SOBOL_DIMS,
    parameter int FRAC_BITS              = SOBOL_FRAC_BITS,
    parameter int INDEX_BITS             = SOBOL_INDEX_BITS,
    parameter int C_M00_AXIS_TDATA_WIDTH = DIMS * FRAC_BITS
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_areset,
    input  logic                                start,
    input  logic [INDEX_BITS-1:0]               start_index,
    input  logic [INDEX_BITS-1:0]               count,
    output logic                                busy,
    output logic                                done,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic [INDEX_BITS-1:0]               sample_index
);

    localparam int            KW     = $clog2(INDEX_BITS);
    localparam logic [KW-1:0] K_LAST = KW'(INDEX_BITS - 1);

    // Direction number tables, one entry per index bit.
    logic [FRAC_BITS-1:0] dir0 [INDEX_BITS];
    logic [FRAC_BITS-1:0] dir1 [INDEX_BITS];

    generate
        for (genvar gi = 0; gi < INDEX_BITS; gi++) begin : g_dir
            localparam logic [63:0] D0 = sobol_dir(0, gi, FRAC_BITS);
            localparam logic [63:0] D1 = sobol_dir(1, gi, FRAC_BITS);
            assign dir0[gi] = D0[FRAC_BITS-1:0];
            assign dir1[gi] = D1[FRAC_BITS-1:0];
        end
    endgenerate

    state_t                 state_reg, state_next;
    logic                   gray_pending_reg;
    logic [KW-1:0]          k_reg;
    logic [INDEX_BITS-1:0]  gray_reg;
    logic [INDEX_BITS-1:0]  idx_reg;
    logic [INDEX_BITS-1:0]  remaining_reg;
    logic [FRAC_BITS-1:0]   acc0_reg, acc1_reg;
    logic                   done_reg;

    logic [INDEX_BITS-1:0]  idx_plus1;
    logic [KW-1:0]          flip_bit;
    logic                   idx_wrap;
    logic                   handshake;

    assign idx_plus1 = idx_reg + INDEX_BITS'(1);

    // Gray-code order: stepping n -> n+1 flips Gray bit ctz(n+1).
    sobol_ctz #(
        .WIDTH (INDEX_BITS),
        .CW    (KW)
    ) u_ctz (
        .value    (idx_plus1),
        .ctz      (flip_bit),
        .all_zero (idx_wrap)
    );

    // The accumulators double as the AXIS data register: they only change on
    // a handshake while in RUN, so tdata is stable under back-pressure.
    assign m00_axis_tdata = {acc1_reg, acc0_reg};
    assign m00_axis_tstrb = '1;
    assign sample_index   = idx_reg;
    assign done           = done_reg;
    assign handshake      = m00_axis_tvalid && m00_axis_tready;

    always_comb begin
        state_next      = state_reg;
        busy            = 1'b0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_next = SEEK;
                end
            end
            SEEK: begin
                busy = 1'b1;
                if (!gray_pending_reg && (k_reg == K_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy            = 1'b1;
                m00_axis_tvalid = 1'b1;
                m00_axis_tlast  = (remaining_reg == INDEX_BITS'(1));
                if (m00_axis_tready && (remaining_reg == INDEX_BITS'(1))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_reg        <= IDLE;
            gray_pending_reg <= 1'b0;
            k_reg            <= '0;
            gray_reg         <= '0;
            idx_reg          <= '0;
            remaining_reg    <= '0;
            acc0_reg         <= '0;
            acc1_reg         <= '0;
            done_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done_reg <= 1'b1;
                        end else begin
`ifdef SOBOL_SKIP_ZERO_EN
                            idx_reg <= (start_index == '0) ? INDEX_BITS'(1) : start_index;
`else
                            idx_reg <= start_index;
`endif
                            remaining_reg    <= count;
                            acc0_reg         <= '0;
                            acc1_reg         <= '0;
                            gray_pending_reg <= 1'b1;
                            k_reg            <= '0;
                        end
                    end
                end
                SEEK: begin
                    // First SEEK cycle registers the Gray code of the latched
                    // index; the following INDEX_BITS cycles fold in one
                    // direction number per set Gray bit.
                    if (gray_pending_reg) begin
                        gray_reg         <= idx_reg ^ (idx_reg >> 1);
                        gray_pending_reg <= 1'b0;
                    end else begin
                        if (gray_reg[k_reg]) begin
                            acc0_reg <= acc0_reg ^ dir0[k_reg];
                            acc1_reg <= acc1_reg ^ dir1[k_reg];
                        end
                        k_reg <= k_reg + KW'(1);
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (remaining_reg == INDEX_BITS'(1)) begin
                            done_reg <= 1'b1;
                        end else begin
                            remaining_reg <= remaining_reg - INDEX_BITS'(1);
                            if (idx_wrap) begin
`ifdef SOBOL_SKIP_ZERO_EN
                                idx_reg  <= INDEX_BITS'(1);
                                acc0_reg <= dir0[0];
                                acc1_reg <= dir1[0];
`else
                                idx_reg  <= '0;
                                acc0_reg <= '0;
                                acc1_reg <= '0;
`endif
                            end else begin
                                idx_reg  <= idx_plus1;
                                acc0_reg <= acc0_reg ^ dir0[flip_bit];
                                acc1_reg <= acc1_reg ^ dir1[flip_bit];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_sobol_generator.sv
// Self-checking bench for axis_sobol_generator. Expected points are computed
// directly from the Sobol definition (Gray code of the index, XOR of
// direction numbers), independent of the generator's incremental update.
module tb_axis_sobol_generator;

`ifdef SOBOL_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic [31:0] start_index;
    logic [31:0] count;
    logic        busy;
    logic        done;
    logic        tready;
    logic        tvalid;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic [31:0] sample_index;

    int tests = 0;
    int fails = 0;

    logic [31:0] v0 [32];
    logic [31:0] v1 [32];
    logic [63:0] obs_q [$];
    logic [31:0] obs_idx_q [$];
    logic [63:0] exp1 [4];

    always #5 clk = ~clk;

    axis_sobol_generator dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (srst),
        .start           (start),
        .start_index     (start_index),
        .count           (count),
        .busy            (busy),
        .done            (done),
        .m00_axis_tready (tready),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tlast  (tlast),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .sample_index    (sample_index)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_point(input logic [31:0] n);
        logic [31:0] g;
        logic [31:0] x0;
        logic [31:0] x1;
        g  = n ^ (n >> 1);
        x0 = '0;
        x1 = '0;
        for (int k = 0; k < 32; k++) begin
            if (g[k]) begin
                x0 = x0 ^ v0[k];
                x1 = x1 ^ v1[k];
            end
        end
        return {x1, x0};
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] n);
        logic [31:0] m;
        m = n + 32'd1;
        if (m == 32'd0 && SKIP) m = 32'd1;
        return m;
    endfunction

    // One burst: pulse start, collect beats with bounded wait, check each beat
    // against the model, hold-stability under stalls, latency and done timing.
    task automatic run_burst(input logic [31:0] s, input logic [31:0] cnt,
                             input bit rand_rdy, input bit stall_en, input bit inject);
        logic [31:0] exp_n;
        int          beats;
        bit          held;
        bit          last_acc;
        bit          finished;
        logic [63:0] h_data;
        logic [31:0] h_idx;
        logic        h_last;
        int          first_valid;
        int          stall_left;
        bit          rdy;
        obs_q.delete();
        obs_idx_q.delete();
        exp_n       = (s == 32'd0 && SKIP) ? 32'd1 : s;
        beats       = 0;
        held        = 1'b0;
        last_acc    = 1'b0;
        finished    = 1'b0;
        first_valid = -1;
        stall_left  = 10;
        h_data      = '0;
        h_idx       = '0;
        h_last      = 1'b0;
        start       = 1'b1;
        start_index = s;
        count       = cnt;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int c = 1; c <= 400 && !finished; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (inject && (c == 5 || c == 34)) begin
                start       = 1'b1;
                start_index = $urandom;
                count       = $urandom_range(1, 5);
            end
            if (last_acc) begin
                chk("done_after_last", done, 1);
                chk("valid_after_last", tvalid, 0);
                chk("busy_after_last", busy, 0);
                finished = 1'b1;
            end else begin
                chk("no_early_done", done, 0);
                if (tvalid) begin
                    if (first_valid < 0) first_valid = c;
                    if (held) begin
                        chk("stall_data_stable", tdata, h_data);
                        chk("stall_index_stable", sample_index, h_idx);
                        chk("stall_last_stable", tlast, h_last);
                    end
                    rdy = rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
                    if (stall_en && beats == 1 && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end
                    tready = rdy;
                    if (rdy) begin
                        chk("beat_data", tdata, model_point(exp_n));
                        chk("beat_index", sample_index, exp_n);
                        chk("beat_last", tlast, (beats == int'(cnt) - 1));
                        obs_q.push_back(tdata);
                        obs_idx_q.push_back(sample_index);
                        beats++;
                        exp_n    = model_next(exp_n);
                        held     = 1'b0;
                        last_acc = (beats == int'(cnt));
                    end else begin
                        held   = 1'b1;
                        h_data = tdata;
                        h_idx  = sample_index;
                        h_last = tlast;
                    end
                end else begin
                    if (held) chk("valid_dropped_in_stall", tvalid, 1);
                    held   = 1'b0;
                    tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
        start = 1'b0;
        chk("burst_finished", finished, 1);
        chk("beat_count", beats, cnt);
        chk("first_valid_latency", first_valid, 33);
        $display("[TB] burst start=%h count=%0d beats=%0d first_valid=%0d", s, cnt, beats, first_valid);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) v0[k] = 32'h8000_0000 >> k;
        v1[0] = 32'h8000_0000;
        for (int k = 1; k < 32; k++) v1[k] = v1[k-1] ^ (v1[k-1] >> 1);
`ifdef SOBOL_SKIP_ZERO_EN
        exp1[0] = 64'h80000000_80000000;
        exp1[1] = 64'h40000000_C0000000;
        exp1[2] = 64'hC0000000_40000000;
        exp1[3] = 64'h60000000_60000000;
`else
        exp1[0] = 64'h00000000_00000000;
        exp1[1] = 64'h80000000_80000000;
        exp1[2] = 64'h40000000_C0000000;
        exp1[3] = 64'hC0000000_40000000;
`endif

        srst = 1'b1; start = 1'b0; start_index = '0; count = '0; tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_sample_index", sample_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("tstrb_ones", tstrb, 8'hFF);
        srst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset checked");

        // 1: index 0, four beats, tready high
        run_burst(32'd0, 32'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("s1_const_data", (i < obs_q.size()) ? obs_q[i] : 64'hx, exp1[i]);
        end

        // 2: single point at index 3
        run_burst(32'd3, 32'd1, 1'b0, 1'b0, 1'b0);
        chk("s2_const_data", (obs_q.size() > 0) ? obs_q[0] : 64'hx, 64'hC0000000_40000000);
        chk("s2_index", (obs_idx_q.size() > 0) ? obs_idx_q[0] : 32'hx, 32'd3);

        // 3: same as 1 under random back-pressure with a 10-cycle stall
        run_burst(32'd0, 32'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("s3_const_data", (i < obs_q.size()) ? obs_q[i] : 64'hx, exp1[i]);
        end

        // 4: index wrap
        run_burst(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("s4_wrap_index", (obs_idx_q.size() > 2) ? obs_idx_q[2] : 32'hx, SKIP ? 32'd1 : 32'd0);
        chk("s4_wrap_data", (obs_q.size() > 2) ? obs_q[2] : 64'hx,
            SKIP ? 64'h80000000_80000000 : 64'h0);

        // 5a: count == 0
        start = 1'b1; start_index = $urandom; count = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("cnt0_done", done, 1);
        chk("cnt0_tvalid", tvalid, 0);
        chk("cnt0_busy", busy, 0);
        @(posedge clk); #1;
        chk("cnt0_done_pulse", done, 0);
        chk("cnt0_no_valid", tvalid, 0);
        $display("[TB] count=0 burst checked");

        // 5b: start pulses during SEEK and RUN are ignored
        run_burst($urandom, 32'd6, 1'b0, 1'b0, 1'b1);

        // random bursts
        for (int r = 0; r < 4; r++) begin
            run_burst($urandom, $urandom_range(1, 5), 1'b1, 1'b0, 1'b0);
        end
        run_burst(32'hFFFF_FFFF - $urandom_range(0, 2), $urandom_range(2, 5), 1'b1, 1'b0, 1'b0);

        // 5c: reset during RUN
        tready = 1'b0;
        start = 1'b1; start_index = $urandom; count = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 60 && !tvalid; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_run_reached", tvalid, 1);
        srst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_tlast", tlast, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tdata", tdata, 0);
        chk("midrst_index", sample_index, 0);
        srst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_done", done, 0);
        chk("postrst_tvalid", tvalid, 0);
        $display("[TB] reset during RUN checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
